mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle sequencer for the MIPS-subset datapath. It replaces single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back, and drives the shared ALU, memory port, PC and register file once per state. It sits between the instruction register's Op/Func fields and the multi-cycle datapath muxes.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- Op  in  6  IR[31:26]; stable from the cycle after the fetch IRWrite.
- Func  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, same cycle.
- MemReady  in  1  memory completion strobe.
- PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath strobes and mux selects.
- ALUSrcB  out  2  00 B, 01 constant 4, 10 SE imm, 11 SE imm<<2.
- ALUCntl  out  4  ALU operation code.
- PCSource  out  2  00 ALU result, 01 ALUOut register.
- Retired  out  1  one-cycle pulse when an instruction completes.
- IllegalOp  out  1  sticky; set on an undecodable instruction.
- State  out  4  current state, for debug.

## Operation
- ALUCntl codes: add 1010, addu 0010, sub 1110, subu 0110, and 0000, or 0001, xor 0011, nor 1100, slt 0101, sltu 1111.
- R-type Func map: 20/21/22/23/24/25/26/27/2A/2B map to the codes above, in that order.
- I-type Op map: 08 addi→1010, 09 addiu→0010, 0C andi→0000, 0D ori→0001, 0A slti→0101, 0B sltiu→1111.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCntl=0010, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle where MemReady=1; the FSM then moves to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUCntl=0010 (branch target into ALUOut). Next state:
  - Op=00 with legal Func → EXEC_R.
  - I-ALU ops → EXEC_I.
  - 23/2B → MEMADR.
  - 04/05 → BRANCH.
  - Otherwise → HALT.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUCntl from Func → WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUCntl from Op → WB_ALU.
- WB_ALU: RegWrite=1, RegDst=(Op==00), MemtoReg=0, Retired=1 → FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCntl=0010 → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1; holds until MemReady → WB_MEM.
- MEM_WR: MemWrite=1, IorD=1; holds until MemReady; Retired=1 in the exit cycle → FETCH.
- WB_MEM: RegWrite=1, RegDst=0, MemtoReg=1, Retired=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCntl=1110, PCSource=01, Retired=1 → FETCH.
  - PCWrite=Zero for Op 04, ~Zero for Op 05.
- HALT: all strobes 0, IllegalOp=1; stays until reset.

## Timing
- Outputs are decoded combinationally from the state register, plus Zero and MemReady where noted.
- While reset is high, all outputs are forced to 0. Reset releases into FETCH with IllegalOp=0.
- Latency with MemReady tied high:
  - R-type and I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
- Each memory wait adds one cycle per MemReady-low cycle.
- MemRead and MemWrite are held constant across wait cycles. No write or PC strobe asserts during a wait.
- Reset asserted in any state, including mid-wait or HALT, returns to FETCH on the next edge. No partial strobes are emitted in the reset cycle.
- MemReady high outside FETCH, MEM_RD or MEM_WR is ignored.

## Configuration
- MC_MEM_HANDSHAKE_EN defined: wait behaviour as described above.
- MC_MEM_HANDSHAKE_EN undefined: MemReady is ignored and treated as constant 1; FETCH, MEM_RD and MEM_WR each last exactly one cycle.

## Test plan
- Reset held 3 cycles mid-MEM_RD → all outputs 0; State=FETCH and IllegalOp=0 after release.
- add (Op=00, Func=20), MemReady=1 → State sequence FETCH, DECODE, EXEC_R, WB_ALU. ALUCntl=1010 in EXEC_R. RegWrite=1 and RegDst=1 in WB_ALU. Single Retired pulse in cycle 4.
- lw (Op=23) with MemReady low for 2 cycles in MEM_RD → 7 cycles total. MemRead and IorD held high throughout the wait. RegWrite and MemtoReg asserted in WB_MEM only.
- bne (Op=05): Zero=0 → PCWrite=1 and PCSource=01 in BRANCH. Repeat with Zero=1 → PCWrite=0. Both take 3 cycles.
- Op=3F → DECODE goes to HALT; IllegalOp=1 and stays after 10 cycles; reset clears it. Repeat with Op=00, Func=08 → HALT.
- Macro undefined with MemReady tied 0 → sw completes in 4 cycles.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle Moore sequencer for the MIPS-subset datapath.
// Latency with MemReady high: R/I-ALU 4, lw 5, sw 4, beq/bne 3 cycles. Each MemReady-low cycle in FETCH/MEM_RD/MEM_WR adds one.
// Backpressure: waits in FETCH/MEM_RD/MEM_WR only while MemReady is low. MemRead and MemWrite stay steady during a wait; write and PC strobes stay low.
// Ports: clk, reset (sync, active-high); Op/Func from the IR; Zero from the ALU; MemReady from the memory port.
//        Datapath strobes and mux selects; Retired pulses once per completed instruction; IllegalOp is sticky until reset; State is for debug.
// Build option: define MC_MEM_HANDSHAKE_EN to honour MemReady. With it undefined, MemReady is ignored and the memory states take one cycle.
module mc_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Func,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUCntl,
   output logic [1:0] PCSource,
   output logic       Retired,
   output logic       IllegalOp,
   output logic [3:0] State
);

   // The encoding is visible on State, so FETCH stays at zero (the reset value).
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_WB_ALU = 4'd4,
      S_MEMADR = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WR = 4'd7,
      S_WB_MEM = 4'd8,
      S_BRANCH = 4'd9,
      S_HALT   = 4'd10
   } state_t;

   state_t     stateQ;
   logic       illegalQ;
   logic       memRdy;
   logic [3:0] rCntl;
   logic       rLegal;
   logic [3:0] iCntl;
   logic       iLegal;

`ifdef MC_MEM_HANDSHAKE_EN
   assign memRdy = MemReady;
`else
   // Without the handshake every memory access finishes in one cycle.
   logic unusedMemReady;
   assign unusedMemReady = MemReady;
   assign memRdy         = 1'b1;
`endif

   // R-type function decode.
   always_comb begin
      rCntl  = 4'b0000;
      rLegal = 1'b1;
      case (Func)
         6'h20:   rCntl = 4'b1010;  // add
         6'h21:   rCntl = 4'b0010;  // addu
         6'h22:   rCntl = 4'b1110;  // sub
         6'h23:   rCntl = 4'b0110;  // subu
         6'h24:   rCntl = 4'b0000;  // and
         6'h25:   rCntl = 4'b0001;  // or
         6'h26:   rCntl = 4'b0011;  // xor
         6'h27:   rCntl = 4'b1100;  // nor
         6'h2A:   rCntl = 4'b0101;  // slt
         6'h2B:   rCntl = 4'b1111;  // sltu
         default: rLegal = 1'b0;
      endcase
   end

   // I-type ALU opcode decode.
   always_comb begin
      iCntl  = 4'b0000;
      iLegal = 1'b1;
      case (Op)
         6'h08:   iCntl = 4'b1010;  // addi
         6'h09:   iCntl = 4'b0010;  // addiu
         6'h0C:   iCntl = 4'b0000;  // andi
         6'h0D:   iCntl = 4'b0001;  // ori
         6'h0A:   iCntl = 4'b0101;  // slti
         6'h0B:   iCntl = 4'b1111;  // sltiu
         default: iLegal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ   <= S_FETCH;
         illegalQ <= 1'b0;
      end else begin
         case (stateQ)
            S_FETCH:  if (memRdy) stateQ <= S_DECODE;
            S_DECODE: begin
               if (Op == 6'h00 && rLegal)           stateQ <= S_EXEC_R;
               else if (iLegal)                     stateQ <= S_EXEC_I;
               else if (Op == 6'h23 || Op == 6'h2B) stateQ <= S_MEMADR;
               else if (Op == 6'h04 || Op == 6'h05) stateQ <= S_BRANCH;
               else begin
                  stateQ   <= S_HALT;
                  illegalQ <= 1'b1;
               end
            end
            S_EXEC_R: stateQ <= S_WB_ALU;
            S_EXEC_I: stateQ <= S_WB_ALU;
            S_WB_ALU: stateQ <= S_FETCH;
            // Only lw and sw reach MEMADR, so anything other than lw is sw.
            S_MEMADR: stateQ <= (Op == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (memRdy) stateQ <= S_WB_MEM;
            S_MEM_WR: if (memRdy) stateQ <= S_FETCH;
            S_WB_MEM: stateQ <= S_FETCH;
            S_BRANCH: stateQ <= S_FETCH;
            S_HALT:   stateQ <= S_HALT;
            default:  stateQ <= S_FETCH;
         endcase
      end
   end

   // Moore decode of the outputs. Reset masks everything, so no partial strobe leaks out in the reset cycle.
   always_comb begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      RegDst    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUCntl   = 4'b0000;
      PCSource  = 2'b00;
      Retired   = 1'b0;
      IllegalOp = 1'b0;
      State     = 4'd0;
      if (!reset) begin
         State     = stateQ;
         IllegalOp = illegalQ;
         case (stateQ)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               ALUCntl = 4'b0010;
               IRWrite = memRdy;
               PCWrite = memRdy;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               ALUCntl = 4'b0010;
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUCntl = rCntl;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUCntl = iCntl;
            end
            S_WB_ALU: begin
               RegWrite = 1'b1;
               RegDst   = (Op == 6'h00);
               Retired  = 1'b1;
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUCntl = 4'b0010;
            end
            S_MEM_RD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
               Retired  = memRdy;
            end
            S_WB_MEM: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               Retired  = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA  = 1'b1;
               ALUCntl  = 4'b1110;
               PCSource = 2'b01;
               Retired  = 1'b1;
               PCWrite  = (Op == 6'h04) ? Zero : ~Zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] Op = 6'h00;
   logic [5:0] Func = 6'h00;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUCntl, State;
   logic       Retired, IllegalOp;

   int checks = 0;
   int errors = 0;

   mc_control_fsm dut (
      .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUCntl(ALUCntl), .PCSource(PCSource), .Retired(Retired),
      .IllegalOp(IllegalOp), .State(State)
   );

   always #5 clk = ~clk;

   logic [22:0] obs;
   assign obs = {State, PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, RegDst,
                 ALUSrcA, ALUSrcB, ALUCntl, PCSource, Retired, IllegalOp};

   // Phase codes as published on the State debug port.
   localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_WB_ALU = 4,
                  P_MEMADR = 5, P_MEM_RD = 6, P_MEM_WR = 7, P_WB_MEM = 8, P_BRANCH = 9, P_HALT = 10;
   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_ILL = 5;

   logic [5:0] rFuncs [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
   logic [3:0] rCodes [10] = '{4'b1010, 4'b0010, 4'b1110, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0101, 4'b1111};
   logic [5:0] iOps   [6]  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B};
   logic [3:0] iCodes [6]  = '{4'b1010, 4'b0010, 4'b0000, 4'b0001, 4'b0101, 4'b1111};
   int         latency [5] = '{4, 4, 5, 4, 3};

   function automatic logic [4:0] rLookup(input logic [5:0] f);
      for (int i = 0; i < 10; i++) if (f == rFuncs[i]) return {1'b1, rCodes[i]};
      return 5'd0;
   endfunction

   function automatic logic [4:0] iLookup(input logic [5:0] o);
      for (int i = 0; i < 6; i++) if (o == iOps[i]) return {1'b1, iCodes[i]};
      return 5'd0;
   endfunction

   function automatic int classOf(input logic [5:0] op, input logic [5:0] fn);
      logic [4:0] d;
      if (op == 6'h00) begin
         d = rLookup(fn);
         return d[4] ? C_R : C_ILL;
      end
      d = iLookup(op);
      if (d[4]) return C_I;
      if (op == 6'h23) return C_LW;
      if (op == 6'h2B) return C_SW;
      if (op == 6'h04 || op == 6'h05) return C_BR;
      return C_ILL;
   endfunction

   // Expected output vector for one cycle of a given phase.
   function automatic logic [22:0] expOut(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input logic rdy);
      logic pcw, irw, iord, mrd, mwr, m2r, rw, rdst, asa, ret, ill;
      logic [1:0] asb, pcs;
      logic [3:0] cntl;
      logic [4:0] d;
      {pcw, irw, iord, mrd, mwr, m2r, rw, rdst, asa, ret, ill} = '0;
      asb = 2'b00; pcs = 2'b00; cntl = 4'b0000;
      case (ph)
         P_FETCH:  begin mrd = 1; asb = 2'b01; cntl = 4'b0010; pcw = rdy; irw = rdy; end
         P_DECODE: begin asb = 2'b11; cntl = 4'b0010; end
         P_EXEC_R: begin asa = 1; d = rLookup(fn); cntl = d[3:0]; end
         P_EXEC_I: begin asa = 1; asb = 2'b10; d = iLookup(op); cntl = d[3:0]; end
         P_WB_ALU: begin rw = 1; rdst = (op == 6'h00); ret = 1; end
         P_MEMADR: begin asa = 1; asb = 2'b10; cntl = 4'b0010; end
         P_MEM_RD: begin mrd = 1; iord = 1; end
         P_MEM_WR: begin mwr = 1; iord = 1; ret = rdy; end
         P_WB_MEM: begin rw = 1; m2r = 1; ret = 1; end
         P_BRANCH: begin asa = 1; cntl = 4'b1110; pcs = 2'b01; ret = 1; pcw = (op == 6'h04) ? z : ~z; end
         P_HALT:   ill = 1;
         default:  ;
      endcase
      return {4'(ph), pcw, irw, iord, mrd, mwr, m2r, rw, rdst, asa, asb, cntl, pcs, ret, ill};
   endfunction

   function automatic logic effReady(input logic mr);
`ifdef MC_MEM_HANDSHAKE_EN
      return mr;
`else
      return 1'b1 | mr;
`endif
   endfunction

   // Runs one instruction from FETCH. zf<0 randomises Zero; pct is the MemReady-high percentage;
   // memLow forces MemReady low for that many leading memory-phase cycles; stopAt returns right after that phase is checked.
   task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int zf, input int pct,
                           input int memLow, input int stopAt, input string tag);
      int q[$];
      int c, idx, cycles, waits, retires, retireAt, lowLeft, ph;
      logic rdy;
      logic [22:0] e;
      c = classOf(op, fn);
      q.push_back(P_FETCH);
      q.push_back(P_DECODE);
      case (c)
         C_R:  begin q.push_back(P_EXEC_R); q.push_back(P_WB_ALU); end
         C_I:  begin q.push_back(P_EXEC_I); q.push_back(P_WB_ALU); end
         C_LW: begin q.push_back(P_MEMADR); q.push_back(P_MEM_RD); q.push_back(P_WB_MEM); end
         C_SW: begin q.push_back(P_MEMADR); q.push_back(P_MEM_WR); end
         C_BR: q.push_back(P_BRANCH);
         default: q.push_back(P_HALT);
      endcase
      idx = 0; cycles = 0; waits = 0; retires = 0; retireAt = 0; lowLeft = memLow;
      while (idx < q.size() && cycles < 300) begin
         ph = q[idx];
         @(negedge clk);
         reset = 1'b0;
         if ((ph == P_MEM_RD || ph == P_MEM_WR) && lowLeft > 0) begin
            MemReady = 1'b0;
            lowLeft--;
         end else begin
            MemReady = ($urandom_range(0, 99) < pct);
         end
         Zero = (zf < 0) ? ($urandom_range(0, 1) == 1) : (zf == 1);
         if (ph == P_FETCH) begin
            Op = 6'($urandom);
            Func = 6'($urandom);
         end else begin
            Op = op;
            Func = fn;
         end
         #1;
         cycles++;
         rdy = effReady(MemReady);
         e = expOut(ph, Op, Func, Zero, rdy);
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s cycle=%0d phase=%0d observed=%h expected=%h", tag, cycles, ph, obs, e);
         end
         if (Retired === 1'b1) begin
            retires++;
            if (retireAt == 0) retireAt = cycles;
         end
         if (ph == stopAt) return;
         if ((ph == P_FETCH || ph == P_MEM_RD || ph == P_MEM_WR) && !rdy) waits++;
         else idx++;
      end
      checks++;
      assert (idx == q.size()) else begin
         errors++;
         $error("FAIL %s_timeout observed=%0d expected=%0d", tag, idx, q.size());
      end
      if (c != C_ILL) begin
         checks++;
         assert (retires == 1) else begin
            errors++;
            $error("FAIL %s_retires observed=%0d expected=1", tag, retires);
         end
         checks++;
         assert (retireAt == latency[c] + waits) else begin
            errors++;
            $error("FAIL %s_latency observed=%0d expected=%0d", tag, retireAt, latency[c] + waits);
         end
      end else begin
         checks++;
         assert (retires == 0) else begin
            errors++;
            $error("FAIL %s_retires observed=%0d expected=0", tag, retires);
         end
      end
   endtask

   // Holds reset high across n clock edges with random inputs; every output must read zero.
   // The following runInstr releases reset and its first check sees FETCH with IllegalOp clear.
   task automatic doReset(input int n, input string tag);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         MemReady = ($urandom_range(0, 1) == 1);
         Zero = ($urandom_range(0, 1) == 1);
         Op = 6'($urandom);
         Func = 6'($urandom);
         #1;
         checks++;
         assert (obs === 23'd0) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, i, obs, 23'd0);
         end
      end
   endtask

   task automatic holdHalt(input int n, input string tag);
      logic [22:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         MemReady = ($urandom_range(0, 1) == 1);
         Zero = ($urandom_range(0, 1) == 1);
         Op = 6'($urandom);
         Func = 6'($urandom);
         #1;
         e = expOut(P_HALT, Op, Func, Zero, 1'b1);
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, i, obs, e);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op, fn;
      int k;
      doReset(3, "reset_init");

      // add, MemReady high: 4 cycles, ALUCntl 1010, RegDst in WB_ALU
      runInstr(6'h00, 6'h20, -1, 100, 0, -1, "add");
      // addi
      runInstr(6'h08, 6'h15, -1, 100, 0, -1, "addi");
      // lw with two wait cycles in MEM_RD
      runInstr(6'h23, 6'h00, -1, 100, 2, -1, "lw_wait");
      // sw with one wait cycle
      runInstr(6'h2B, 6'h00, -1, 100, 1, -1, "sw_wait");
      // bne with Zero low then high
      runInstr(6'h05, 6'h11, 0, 100, 0, -1, "bne_z0");
      runInstr(6'h05, 6'h11, 1, 100, 0, -1, "bne_z1");
      runInstr(6'h04, 6'h00, 1, 100, 0, -1, "beq_z1");
      runInstr(6'h04, 6'h00, 0, 100, 0, -1, "beq_z0");

      // reset held 3 cycles while the FSM is in MEM_RD
      runInstr(6'h23, 6'h00, -1, 100, 5, P_MEM_RD, "lw_cut");
      doReset(3, "reset_mem_rd");
      runInstr(6'h00, 6'h2A, -1, 100, 0, -1, "slt_after_reset");

      // undecodable instructions halt until reset
      runInstr(6'h3F, 6'h00, -1, 100, 0, -1, "op3f");
      holdHalt(10, "halt_op3f");
      doReset(2, "reset_halt1");
      runInstr(6'h00, 6'h08, -1, 100, 0, -1, "func08");
      holdHalt(10, "halt_func08");
      doReset(1, "reset_halt2");

`ifndef MC_MEM_HANDSHAKE_EN
      // MemReady tied low has no effect without the handshake
      runInstr(6'h2B, 6'h00, -1, 0, 0, -1, "sw_ready0");
      runInstr(6'h23, 6'h00, -1, 0, 0, -1, "lw_ready0");
`endif

      // random instruction mix with random MemReady and Zero
      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 11);
         fn = 6'($urandom);
         case (k)
            0, 1, 2: begin op = 6'h00; fn = rFuncs[$urandom_range(0, 9)]; end
            3, 4:    op = iOps[$urandom_range(0, 5)];
            5, 6:    op = 6'h23;
            7, 8:    op = 6'h2B;
            9, 10:   op = ($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05;
            default: op = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h02;
         endcase
         runInstr(op, fn, -1, $urandom_range(40, 100), $urandom_range(0, 3), -1, "rand");
         if (classOf(op, fn) == C_ILL) begin
            holdHalt(3, "rand_halt");
            doReset($urandom_range(1, 3), "rand_reset");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
